// File: rtl/button_mode_sequencer_pkg.sv
// button_mode_sequencer_pkg: shared mode encoding, default debounce length and instruction widths
package button_mode_sequencer_pkg;
  typedef enum logic [1:0] {
    MODE_F1  = 2'd0,
    MODE_F2  = 2'd1,
    MODE_F3  = 2'd2,
    MODE_BAD = 2'd3
  } mode_e;
  localparam int DEFAULT_DEBOUNCE_CYCLES = 500000;
  localparam int F1_W = 4;
  localparam int F2_W = 4;
  localparam int F3_W = 5;
endpackage

// File: rtl/button_mode_sequencer_debouncer.sv
// button_debouncer: synchroniser chain, hold-time debounce counter, stable level and rising-edge pulse
// Ports: i_clk, i_rst_n (async active-low), i_raw (asynchronous pin),
//        o_stable (debounced level), o_rise (one-cycle pulse on stable 0->1)
module button_debouncer #(
  parameter int DEBOUNCE_CYCLES = 500000,
  parameter int CNT_W           = 20,
  parameter int SYNC_STAGES     = 2
) (
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_raw,
  output logic o_stable,
  output logic o_rise
);
  logic [SYNC_STAGES-1:0] r_sync;
  logic [CNT_W-1:0]       r_cnt;
  logic                   r_stable;
  logic                   r_stable_q;
  logic                   w_sync;
  assign w_sync   = r_sync[SYNC_STAGES-1];
  assign o_stable = r_stable;
  assign o_rise   = r_stable & ~r_stable_q;
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_sync     <= '0;
      r_cnt      <= '0;
      r_stable   <= 1'b0;
      r_stable_q <= 1'b0;
    end else begin
      r_sync     <= {r_sync[SYNC_STAGES-2:0], i_raw};
      r_stable_q <= r_stable;
      // Any return to the accepted level restarts the hold count, so short glitches never qualify
      if (w_sync == r_stable) r_cnt <= '0;
      else if (r_cnt == CNT_W'(DEBOUNCE_CYCLES - 1)) begin
        r_stable <= w_sync;
        r_cnt    <= '0;
      end else r_cnt <= r_cnt + 1'b1;
    end
  end
endmodule

// File: rtl/button_mode_sequencer.sv
// button_mode_sequencer: debounced button/switch front end, three-function mode FSM and instruction routing
// Ports: sysclk, reset_n (async active-low); raw East/West/North/South/change/SW0..SW3;
//        func_index (active function), func1/2/3_instruction (mode-gated field levels),
//        instr_strobe (one-cycle new-press pulse), soft_reset (debounced SW0)
module button_mode_sequencer
  import button_mode_sequencer_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES,
  parameter int CNT_W           = 20,
  parameter int SYNC_STAGES     = 2
) (
  input  logic            sysclk,
  input  logic            reset_n,
  input  logic            East,
  input  logic            West,
  input  logic            North,
  input  logic            South,
  input  logic            change,
  input  logic            SW0,
  input  logic            SW1,
  input  logic            SW2,
  input  logic            SW3,
  output logic [1:0]      func_index,
  output logic [F1_W-1:0] func1_instruction,
  output logic [F2_W-1:0] func2_instruction,
  output logic [F3_W-1:0] func3_instruction,
  output logic            instr_strobe,
  output logic            soft_reset
);
  // Bit order: 0 East, 1 West, 2 North, 3 South, 4 SW0, 5 SW1, 6 SW2, 7 SW3, 8 change
  logic [8:0] w_raw;
  logic [8:0] w_stable;
  logic [8:0] w_rise;
  logic       w_strobe;
  logic       w_unused;
  mode_e      r_mode;
  mode_e      w_mode_next;
  assign w_raw = {change, SW3, SW2, SW1, SW0, South, North, West, East};
  for (genvar g = 0; g < 9; g++) begin : g_db
    button_debouncer #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
      .CNT_W          (CNT_W),
      .SYNC_STAGES    (SYNC_STAGES)
    ) u_db (
      .i_clk   (sysclk),
      .i_rst_n (reset_n),
      .i_raw   (w_raw[g]),
      .o_stable(w_stable[g]),
      .o_rise  (w_rise[g])
    );
  end
  assign w_unused = &{1'b0, w_rise[6:4], w_stable[8]};
  always_ff @(posedge sysclk or negedge reset_n) begin
    if (!reset_n) r_mode <= MODE_F1;
    else r_mode <= w_mode_next;
  end
  always_comb begin
    w_mode_next = r_mode;
    w_mode_next = (r_mode == MODE_BAD) ? MODE_F1 :
                  !w_rise[8]           ? r_mode  :
                  (r_mode == MODE_F1)  ? MODE_F2 :
                  (r_mode == MODE_F2)  ? MODE_F3 : MODE_F1;
    // A change press in the same cycle wins: the button press lands in the new mode as a level only
    w_strobe = ~w_rise[8] & ((|w_rise[3:0]) | ((r_mode == MODE_F3) & w_rise[7]));
  end
  always_ff @(posedge sysclk or negedge reset_n) begin
    if (!reset_n) begin
      func_index        <= 2'd0;
      func1_instruction <= '0;
      func2_instruction <= '0;
      func3_instruction <= '0;
      instr_strobe      <= 1'b0;
      soft_reset        <= 1'b0;
    end else begin
      func_index        <= r_mode;
      func1_instruction <= (r_mode == MODE_F1) ? {w_stable[7], w_stable[6], w_stable[5], w_stable[0]} : '0;
      func2_instruction <= (r_mode == MODE_F2) ? {w_stable[0], w_stable[1], w_stable[2], w_stable[3]} : '0;
      func3_instruction <= (r_mode == MODE_F3) ? {w_stable[0], w_stable[1], w_stable[2], w_stable[3], w_stable[7]} : '0;
      instr_strobe      <= w_strobe;
      soft_reset        <= w_stable[4];
    end
  end
endmodule

// File: tb/tb_button_mode_sequencer.sv
// tb_button_mode_sequencer: scoreboard bench; stimulus queues timed output snapshots, monitor checks every output change
module tb_button_mode_sequencer;
  logic       sysclk;
  logic       reset_n;
  logic       East, West, North, South, change, SW0, SW1, SW2, SW3;
  logic [1:0] func_index;
  logic [3:0] func1_instruction;
  logic [3:0] func2_instruction;
  logic [4:0] func3_instruction;
  logic       instr_strobe;
  logic       soft_reset;

  button_mode_sequencer #(
    .DEBOUNCE_CYCLES(4),
    .CNT_W          (3),
    .SYNC_STAGES    (2)
  ) dut (
    .sysclk           (sysclk),
    .reset_n          (reset_n),
    .East             (East),
    .West             (West),
    .North            (North),
    .South            (South),
    .change           (change),
    .SW0              (SW0),
    .SW1              (SW1),
    .SW2              (SW2),
    .SW3              (SW3),
    .func_index       (func_index),
    .func1_instruction(func1_instruction),
    .func2_instruction(func2_instruction),
    .func3_instruction(func3_instruction),
    .instr_strobe     (instr_strobe),
    .soft_reset       (soft_reset)
  );

  typedef struct {
    int          cyc;
    logic [16:0] v;
    string       nm;
  } exp_t;

  exp_t        q[$];
  exp_t        e;
  int          cyc;
  int          tests;
  int          fails;
  logic [16:0] cur;
  logic [16:0] prev;

  initial sysclk = 1'b0;
  always #5 sysclk = ~sysclk;

  initial cyc = 0;
  always @(posedge sysclk) cyc <= cyc + 1;

  // Snapshot layout: {func_index, func1, func2, func3, instr_strobe, soft_reset}
  always @(negedge sysclk) begin
    cur = {func_index, func1_instruction, func2_instruction, func3_instruction, instr_strobe, soft_reset};
    if (!reset_n) begin
      tests++;
      if (cur !== 17'h0) begin
        fails++;
        $display("FAIL reset_zero: got %h want 00000 @cyc %0d", cur, cyc);
      end
    end else if (cur !== prev) begin
      tests++;
      if (q.size() == 0) begin
        fails++;
        $display("FAIL unexpected_change: got %h (was %h) @cyc %0d, nothing expected", cur, prev, cyc);
      end else begin
        e = q.pop_front();
        if (e.v !== cur || e.cyc != cyc) begin
          fails++;
          $display("FAIL %s: got %h @cyc %0d, want %h @cyc %0d", e.nm, cur, cyc, e.v, e.cyc);
        end
      end
    end else if (q.size() > 0 && q[0].cyc < cyc) begin
      tests++;
      fails++;
      e = q.pop_front();
      $display("FAIL %s: still %h @cyc %0d, want %h @cyc %0d", e.nm, cur, cyc, e.v, e.cyc);
    end
    prev = cur;
  end

  task automatic tick(input int n);
    for (int i = 0; i < n; i++) @(posedge sysclk);
    #1;
  endtask

  task automatic push(input int dly, input logic [1:0] fi, input logic [3:0] f1, input logic [3:0] f2,
                      input logic [4:0] f3, input logic st, input logic sr, input string nm);
    q.push_back('{cyc + dly, {fi, f1, f2, f3, st, sr}, nm});
  endtask

  // Qualified change press; the mode becomes visible SYNC_STAGES+DEBOUNCE_CYCLES+2 = 8 cycles after the raw edge
  task automatic press(input logic [1:0] fi, input logic [3:0] f1, input logic [3:0] f2,
                       input logic [4:0] f3, input logic sr, input string nm);
    change = 1'b1;
    push(8, fi, f1, f2, f3, 1'b0, sr, nm);
    tick(6);
    change = 1'b0;
    tick(10);
  endtask

  initial begin
    tests   = 0;
    fails   = 0;
    prev    = '0;
    reset_n = 1'b0;
    {change, SW3, SW2, SW1, SW0, South, North, West, East} = '0;
    for (int i = 0; i < 8; i++) begin
      {change, SW3, SW2, SW1, SW0, South, North, West, East} = 9'($urandom);
      tick(1);
    end
    {change, SW3, SW2, SW1, SW0, South, North, West, East} = '0;
    tick(1);
    reset_n = 1'b1;
    tick(20);

    for (int i = 0; i < 5; i++) begin
      change = 1'b1;
      tick(3);
      change = 1'b0;
      tick(5);
    end
    change = 1'b1;
    push(8, 2'd1, 4'h0, 4'h0, 5'h00, 1'b0, 1'b0, "held_change_to_f2");
    tick(10);
    change = 1'b0;
    tick(12);

    press(2'd2, 4'h0, 4'h0, 5'h00, 1'b0, "press_to_f3");
    SW3 = 1'b1;
    push(7, 2'd2, 4'h0, 4'h0, 5'h01, 1'b1, 1'b0, "f3_sw3_strobe");
    push(8, 2'd2, 4'h0, 4'h0, 5'h01, 1'b0, 1'b0, "f3_sw3_strobe_end");
    tick(10);
    press(2'd0, 4'h8, 4'h0, 5'h00, 1'b0, "wrap_to_f1_f3_zero");
    press(2'd1, 4'h0, 4'h0, 5'h00, 1'b0, "press_to_f2");
    SW3 = 1'b0;
    tick(10);
    SW0 = 1'b1;
    push(7, 2'd1, 4'h0, 4'h0, 5'h00, 1'b0, 1'b1, "soft_reset_on");
    tick(10);
    SW0 = 1'b0;
    push(7, 2'd1, 4'h0, 4'h0, 5'h00, 1'b0, 1'b0, "soft_reset_off");
    tick(10);

    North = 1'b1;
    push(7, 2'd1, 4'h0, 4'h2, 5'h00, 1'b1, 1'b0, "f2_north_press");
    push(8, 2'd1, 4'h0, 4'h2, 5'h00, 1'b0, 1'b0, "f2_north_strobe_end");
    tick(10);
    North = 1'b0;
    push(7, 2'd1, 4'h0, 4'h0, 5'h00, 1'b0, 1'b0, "f2_north_release");
    tick(10);

    press(2'd2, 4'h0, 4'h0, 5'h00, 1'b0, "to_f3_again");
    press(2'd0, 4'h0, 4'h0, 5'h00, 1'b0, "to_f1_again");

    // East reaches the F1 bus for one cycle before the mode register's effect appears; no strobe
    change = 1'b1;
    East   = 1'b1;
    push(7, 2'd0, 4'h1, 4'h0, 5'h00, 1'b0, 1'b0, "same_cycle_f1_level");
    push(8, 2'd1, 4'h0, 4'h8, 5'h00, 1'b0, 1'b0, "same_cycle_new_mode");
    tick(10);
    change = 1'b0;
    East   = 1'b0;
    push(7, 2'd1, 4'h0, 4'h0, 5'h00, 1'b0, 1'b0, "east_release_f2");
    tick(10);

    press(2'd2, 4'h0, 4'h0, 5'h00, 1'b0, "to_f3_for_reset");
    SW3 = 1'b1;
    tick(4);
    reset_n = 1'b0;
    tick(1);
    reset_n = 1'b1;
    push(7, 2'd0, 4'h8, 4'h0, 5'h00, 1'b0, 1'b0, "sw3_requalify_after_reset");
    tick(10);
    SW3 = 1'b0;
    push(7, 2'd0, 4'h0, 4'h0, 5'h00, 1'b0, 1'b0, "sw3_release_f1");
    tick(10);

    for (int i = 0; i < 50 && q.size() > 0; i++) tick(1);
    tests++;
    if (q.size() != 0) begin
      fails++;
      $display("FAIL scoreboard_drain: %0d entries left, want 0", q.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
